patch_signal_controller: RTL and testbench

Controller at the other end of a patched module's control port. Every patched signal is exported on the module's `control_port_in` and re-imported from its `control_port_out`. This block receives the exported bus, passes it back unchanged by default, and applies a programmed override mask/value pattern once a programmed trigger condition is seen on the observed signals. It sits between each patched module and the SoC patch configuration bus.

---
 rtl/patch_signal_controller_if.sv | 16 +
 rtl/patch_signal_controller.sv | 167 ++++++++++++++++
 tb/tb_patch_signal_controller.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/patch_signal_controller_if.sv
// patch_signal_controller_if
//   Configuration bus between the SoC patch configuration master and a
//   patch_signal_controller.
//   cfg_valid : write strobe, at most one write per cycle
//   cfg_addr  : register address (0..7)
//   cfg_data  : write data, LSB-aligned
//   cfg_err   : registered one-cycle pulse when a write is rejected
interface patch_signal_controller_if;
  logic        cfg_valid;
  logic [2:0]  cfg_addr;
  logic [15:0] cfg_data;
  logic        cfg_err;

  modport master (output cfg_valid, output cfg_addr, output cfg_data, input cfg_err);
  modport slave  (input cfg_valid, input cfg_addr, input cfg_data, output cfg_err);
endinterface

// File: rtl/patch_signal_controller.sv
// patch_signal_controller
//   Sits on the control port of a patched module. The exported signals
//   (control_port_in) are passed back unchanged (control_port_out) until a
//   programmed trigger pattern is seen while ARMED; then a mask/value override
//   is applied for DURATION cycles (or until disarm when DURATION is 0).
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   cfg               : configuration bus (slave side)
//   control_port_in   : observed signals from the patched module
//   control_port_out  : controlled signals back to the patched module
//   state             : 0 IDLE, 1 ARMED, 2 ACTIVE
//   active            : high while ACTIVE
//   trig_count        : trigger hits, saturating at 255
// Register map: 0 TRIG_MASK, 1 TRIG_VAL, 2 OVR_MASK, 3 OVR_VAL, 4 DURATION,
//   5 CTRL (bit0 arm, bit1 disarm, bit2 rearm), 6-7 reserved.
// WIDTH and DUR_W must not exceed the 16-bit write data width.
module patch_signal_controller #(
  parameter int WIDTH = 4,
  parameter int DUR_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  patch_signal_controller_if.slave cfg,
  input  logic [WIDTH-1:0]         control_port_in,
  output logic [WIDTH-1:0]         control_port_out,
  output logic [1:0]               state,
  output logic                     active,
  output logic [7:0]               trig_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    ACTIVE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   trig_mask_q, trig_mask_d;
  logic [WIDTH-1:0]   trig_val_q, trig_val_d;
  logic [WIDTH-1:0]   ovr_mask_q, ovr_mask_d;
  logic [WIDTH-1:0]   ovr_val_q, ovr_val_d;
  logic [DUR_W-1:0]   duration_q, duration_d;
  logic               rearm_q, rearm_d;
  logic [DUR_W-1:0]   count_q, count_d;
  logic [7:0]         trig_count_q, trig_count_d;
  logic               cfg_err_q, cfg_err_d;

  logic match;
  logic ctrl_wr;
  logic arm_cmd;
  logic disarm_cmd;

  assign match      = ((control_port_in & trig_mask_q) == (trig_val_q & trig_mask_q));
  assign ctrl_wr    = cfg.cfg_valid && (cfg.cfg_addr == 3'd5);
  assign arm_cmd    = ctrl_wr && cfg.cfg_data[0];
  assign disarm_cmd = ctrl_wr && cfg.cfg_data[1];

  always_comb begin
    state_d      = state_q;
    trig_mask_d  = trig_mask_q;
    trig_val_d   = trig_val_q;
    ovr_mask_d   = ovr_mask_q;
    ovr_val_d    = ovr_val_q;
    duration_d   = duration_q;
    rearm_d      = rearm_q;
    count_d      = count_q;
    trig_count_d = trig_count_q;
    cfg_err_d    = 1'b0;

    // Register writes: pattern registers are frozen outside IDLE so a running
    // override can never see a half-updated configuration.
    if (cfg.cfg_valid) begin
      case (cfg.cfg_addr)
        3'd0, 3'd1, 3'd2, 3'd3, 3'd4: begin
          if (state_q == IDLE) begin
            case (cfg.cfg_addr)
              3'd0:    trig_mask_d = cfg.cfg_data[WIDTH-1:0];
              3'd1:    trig_val_d  = cfg.cfg_data[WIDTH-1:0];
              3'd2:    ovr_mask_d  = cfg.cfg_data[WIDTH-1:0];
              3'd3:    ovr_val_d   = cfg.cfg_data[WIDTH-1:0];
              default: duration_d  = cfg.cfg_data[DUR_W-1:0];
            endcase
          end else begin
            cfg_err_d = 1'b1;
          end
        end
        3'd5:    rearm_d   = cfg.cfg_data[2];
        default: cfg_err_d = 1'b1;
      endcase
    end

    // Disarm is checked first in every state so it wins over arm, match
    // and expiry alike.
    case (state_q)
      IDLE: begin
        if (arm_cmd && !disarm_cmd) begin
          state_d = ARMED;
        end
      end
      ARMED: begin
        if (disarm_cmd) begin
          state_d = IDLE;
        end else if (match) begin
          state_d = ACTIVE;
          count_d = duration_q;
          if (trig_count_q != 8'hFF) begin
            trig_count_d = trig_count_q + 8'd1;
          end
        end
      end
      ACTIVE: begin
        if (disarm_cmd) begin
          state_d = IDLE;
        end else if (duration_q != '0) begin
          // The counter holds the cycles left including this one, so the
          // exit edge is the one where it steps from 1 to 0.
          count_d = count_q - DUR_W'(1);
          if (count_q == DUR_W'(1)) begin
            state_d = rearm_q ? ARMED : IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      trig_mask_q  <= '0;
      trig_val_q   <= '0;
      ovr_mask_q   <= '0;
      ovr_val_q    <= '0;
      duration_q   <= '0;
      rearm_q      <= 1'b0;
      count_q      <= '0;
      trig_count_q <= '0;
      cfg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      trig_mask_q  <= trig_mask_d;
      trig_val_q   <= trig_val_d;
      ovr_mask_q   <= ovr_mask_d;
      ovr_val_q    <= ovr_val_d;
      duration_q   <= duration_d;
      rearm_q      <= rearm_d;
      count_q      <= count_d;
      trig_count_q <= trig_count_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  // Per-bit override mux; purely combinational from control_port_in.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign control_port_out[gi] = ((state_q == ACTIVE) && ovr_mask_q[gi]) ?
                                    ovr_val_q[gi] : control_port_in[gi];
    end
  endgenerate

  assign state       = state_q;
  assign active      = (state_q == ACTIVE);
  assign trig_count  = trig_count_q;
  assign cfg.cfg_err = cfg_err_q;

endmodule

// File: tb/tb_patch_signal_controller.sv
module tb_patch_signal_controller;
  logic       clk;
  logic       rst;
  logic [3:0] cpi;
  logic [3:0] cpo;
  logic [1:0] state;
  logic       active;
  logic [7:0] trig_count;

  int n_cmp;
  int n_bad;

  patch_signal_controller_if cfg_bus ();

  patch_signal_controller #(.WIDTH(4), .DUR_W(8)) dut (
    .clk              (clk),
    .rst              (rst),
    .cfg              (cfg_bus),
    .control_port_in  (cpi),
    .control_port_out (cpo),
    .state            (state),
    .active           (active),
    .trig_count       (trig_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [15:0] d);
    cfg_bus.cfg_valid = 1'b1;
    cfg_bus.cfg_addr  = a;
    cfg_bus.cfg_data  = d;
    $display("cfg write addr=%0d data=0x%h state=%0d", a, d, state);
    step();
    cfg_bus.cfg_valid = 1'b0;
  endtask

  task automatic program_regs(input logic [3:0] tm, input logic [3:0] tv,
                              input logic [3:0] om, input logic [3:0] ov,
                              input logic [7:0] dur);
    cfg_write(3'd0, {12'd0, tm});
    cfg_write(3'd1, {12'd0, tv});
    cfg_write(3'd2, {12'd0, om});
    cfg_write(3'd3, {12'd0, ov});
    cfg_write(3'd4, {8'd0, dur});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cfg_bus.cfg_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    cpi = 4'b1010;
    do_reset();
    #1;
    n_cmp++; if (cpo !== 4'b1010) begin n_bad++; $display("FAIL reset_out: got %b want 1010", cpo); end
    n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", state); end
    n_cmp++; if (trig_count !== 8'd0) begin n_bad++; $display("FAIL reset_trig: got %0d want 0", trig_count); end
    n_cmp++; if (active !== 1'b0) begin n_bad++; $display("FAIL reset_active: got %b want 0", active); end
    n_cmp++; if (cfg_bus.cfg_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", cfg_bus.cfg_err); end
    $display("test_reset done");
  endtask

  task automatic test_one_shot();
    cpi = 4'b0000;
    do_reset();
    program_regs(4'b0001, 4'b0001, 4'b0010, 4'b0000, 8'd3);
    cfg_write(3'd5, 16'h0001);
    // cycle t
    cpi = 4'b0011;
    #1;
    n_cmp++; if (state !== 2'd1) begin n_bad++; $display("FAIL oneshot_armed: got %0d want 1", state); end
    n_cmp++; if (cpo !== 4'b0011) begin n_bad++; $display("FAIL oneshot_pass_t: got %b want 0011", cpo); end
    for (int i = 1; i <= 3; i++) begin
      step();
      n_cmp++; if (cpo !== 4'b0001) begin n_bad++; $display("FAIL oneshot_ovr t+%0d: got %b want 0001", i, cpo); end
      n_cmp++; if (active !== 1'b1) begin n_bad++; $display("FAIL oneshot_active t+%0d: got %b want 1", i, active); end
    end
    step();
    n_cmp++; if (cpo !== 4'b0011) begin n_bad++; $display("FAIL oneshot_pass_t4: got %b want 0011", cpo); end
    n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL oneshot_idle: got %0d want 0", state); end
    n_cmp++; if (trig_count !== 8'd1) begin n_bad++; $display("FAIL oneshot_trig: got %0d want 1", trig_count); end
    $display("test_one_shot done");
  endtask

  task automatic test_rearm();
    logic [1:0] exp_state;
    cpi = 4'b0000;
    do_reset();
    program_regs(4'b0001, 4'b0001, 4'b0010, 4'b0000, 8'd2);
    cpi = 4'b0011;
    cfg_write(3'd5, 16'h0005);
    for (int k = 0; k < 9; k++) begin
      exp_state = (k % 3 == 0) ? 2'd1 : 2'd2;
      n_cmp++; if (state !== exp_state) begin n_bad++; $display("FAIL rearm_state k=%0d: got %0d want %0d", k, state, exp_state); end
      n_cmp++; if (trig_count !== 8'((k + 2) / 3)) begin n_bad++; $display("FAIL rearm_trig k=%0d: got %0d want %0d", k, trig_count, (k + 2) / 3); end
      n_cmp++; if (cpo !== ((exp_state == 2'd2) ? 4'b0001 : 4'b0011)) begin n_bad++; $display("FAIL rearm_out k=%0d: got %b", k, cpo); end
      step();
    end
    n_cmp++; if (trig_count !== 8'd3) begin n_bad++; $display("FAIL rearm_trig_final: got %0d want 3", trig_count); end
    cfg_write(3'd5, 16'h0002);
    n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL rearm_disarm: got %0d want 0", state); end
    $display("test_rearm done");
  endtask

  task automatic test_sticky();
    cpi = 4'b1010;
    do_reset();
    program_regs(4'h0, 4'h0, 4'hF, 4'h5, 8'd0);
    cfg_write(3'd5, 16'h0001);
    n_cmp++; if (state !== 2'd1) begin n_bad++; $display("FAIL sticky_armed: got %0d want 1", state); end
    for (int i = 0; i < 50; i++) begin
      step();
      cpi = 4'(i);
      #1;
      n_cmp++; if (cpo !== 4'h5) begin n_bad++; $display("FAIL sticky_hold i=%0d: got %h want 5", i, cpo); end
    end
    n_cmp++; if (trig_count !== 8'd1) begin n_bad++; $display("FAIL sticky_trig: got %0d want 1", trig_count); end
    cpi = 4'b1100;
    cfg_write(3'd5, 16'h0002);
    n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL sticky_disarm_state: got %0d want 0", state); end
    n_cmp++; if (cpo !== 4'b1100) begin n_bad++; $display("FAIL sticky_disarm_out: got %b want 1100", cpo); end
    $display("test_sticky done");
  endtask

  task automatic test_rejected();
    cpi = 4'b0000;
    do_reset();
    program_regs(4'hF, 4'hF, 4'hF, 4'h3, 8'd0);
    n_cmp++; if (cfg_bus.cfg_err !== 1'b0) begin n_bad++; $display("FAIL rej_ok_write: got %b want 0", cfg_bus.cfg_err); end
    cfg_write(3'd5, 16'h0001);
    cfg_write(3'd3, 16'h000C);
    n_cmp++; if (cfg_bus.cfg_err !== 1'b1) begin n_bad++; $display("FAIL rej_armed_err: got %b want 1", cfg_bus.cfg_err); end
    step();
    n_cmp++; if (cfg_bus.cfg_err !== 1'b0) begin n_bad++; $display("FAIL rej_armed_pulse: got %b want 0", cfg_bus.cfg_err); end
    cfg_write(3'd7, 16'h0001);
    n_cmp++; if (cfg_bus.cfg_err !== 1'b1) begin n_bad++; $display("FAIL rej_addr7_err: got %b want 1", cfg_bus.cfg_err); end
    step();
    n_cmp++; if (cfg_bus.cfg_err !== 1'b0) begin n_bad++; $display("FAIL rej_addr7_pulse: got %b want 0", cfg_bus.cfg_err); end
    cfg_write(3'd5, 16'h0001);
    n_cmp++; if (cfg_bus.cfg_err !== 1'b0) begin n_bad++; $display("FAIL rej_arm_in_armed: got %b want 0", cfg_bus.cfg_err); end
    n_cmp++; if (state !== 2'd1) begin n_bad++; $display("FAIL rej_still_armed: got %0d want 1", state); end
    cpi = 4'hF;
    step();
    n_cmp++; if (cpo !== 4'h3) begin n_bad++; $display("FAIL rej_ovr_val_kept: got %h want 3", cpo); end
    cfg_write(3'd5, 16'h0002);
    cfg_write(3'd6, 16'h0000);
    n_cmp++; if (cfg_bus.cfg_err !== 1'b1) begin n_bad++; $display("FAIL rej_addr6_idle: got %b want 1", cfg_bus.cfg_err); end
    $display("test_rejected done");
  endtask

  task automatic test_precedence();
    cpi = 4'b0110;
    do_reset();
    cfg_write(3'd5, 16'h0003);
    n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL prec_arm_disarm: got %0d want 0", state); end
    cfg_write(3'd5, 16'h0001);
    // all-zero trigger mask matches now, but disarm in the same cycle wins
    cfg_write(3'd5, 16'h0002);
    n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL prec_disarm_match: got %0d want 0", state); end
    n_cmp++; if (trig_count !== 8'd0) begin n_bad++; $display("FAIL prec_trig: got %0d want 0", trig_count); end
    $display("test_precedence done");
  endtask

  task automatic test_reset_mid();
    cpi = 4'b0000;
    do_reset();
    program_regs(4'b0001, 4'b0001, 4'hF, 4'h5, 8'd5);
    cfg_write(3'd5, 16'h0005);
    cpi = 4'b0001;
    step();
    step();
    n_cmp++; if (cpo !== 4'h5) begin n_bad++; $display("FAIL mid_active2: got %h want 5", cpo); end
    rst = 1'b1;
    cfg_bus.cfg_valid = 1'b1;
    cfg_bus.cfg_addr  = 3'd3;
    cfg_bus.cfg_data  = 16'h000F;
    step();
    rst = 1'b0;
    cfg_bus.cfg_valid = 1'b0;
    #1;
    n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL mid_state: got %0d want 0", state); end
    n_cmp++; if (cpo !== 4'b0001) begin n_bad++; $display("FAIL mid_pass: got %b want 0001", cpo); end
    n_cmp++; if (trig_count !== 8'd0) begin n_bad++; $display("FAIL mid_trig: got %0d want 0", trig_count); end
    n_cmp++; if (cfg_bus.cfg_err !== 1'b0) begin n_bad++; $display("FAIL mid_err: got %b want 0", cfg_bus.cfg_err); end
    cpi = 4'b0110;
    cfg_write(3'd5, 16'h0001);
    step();
    n_cmp++; if (state !== 2'd2) begin n_bad++; $display("FAIL mid_rearm_active: got %0d want 2", state); end
    n_cmp++; if (cpo !== 4'b0110) begin n_bad++; $display("FAIL mid_no_ovr: got %b want 0110", cpo); end
    step();
    n_cmp++; if (state !== 2'd2) begin n_bad++; $display("FAIL mid_sticky: got %0d want 2", state); end
    n_cmp++; if (trig_count !== 8'd1) begin n_bad++; $display("FAIL mid_trig1: got %0d want 1", trig_count); end
    $display("test_reset_mid done");
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    cpi = 4'b0000;
    cfg_bus.cfg_valid = 1'b0;
    cfg_bus.cfg_addr  = 3'd0;
    cfg_bus.cfg_data  = 16'd0;
    test_reset();
    test_one_shot();
    test_rearm();
    test_sticky();
    test_rejected();
    test_precedence();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
